// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types and digit limits for the stopwatch seconds/minutes stage
package sw_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_HIGH_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;
endpackage

// File: rtl/sw_bcd_cnt.sv
// rtl/sw_bcd_cnt.sv - one BCD digit with enable, clear, programmable limit and carry-out
module sw_bcd_cnt
  import sw_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [DIGIT_W-1:0] i_limit,
  output logic [DIGIT_W-1:0] o_q,
  output logic [DIGIT_W-1:0] o_q_nxt,
  output logic               o_carry
);
  logic [DIGIT_W-1:0] r_q;
  logic               w_at_limit;

  // >= rather than == so a digit can never escape above its limit
  assign w_at_limit = (r_q >= i_limit);
  assign o_carry    = i_en & w_at_limit;

  always_comb begin
    o_q_nxt = r_q;
    if (i_clr) begin
      o_q_nxt = '0;
    end else if (i_en) begin
      o_q_nxt = w_at_limit ? '0 : r_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= o_q_nxt;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/sw_gen_sec_min.sv
// rtl/sw_gen_sec_min.sv - stopwatch seconds/minutes counter with run, pause and lap freeze
module sw_gen_sec_min
  import sw_pkg::*;
#(
  parameter int MIN_MAX = 59
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_sec,
  input  logic               start,
  input  logic               stop,
  input  logic               lap,
  input  logic               clear,
  output logic [DIGIT_W-1:0] sec_low,
  output logic [DIGIT_W-1:0] sec_high,
  output logic [DIGIT_W-1:0] min_low,
  output logic [DIGIT_W-1:0] min_high,
  output logic               running,
  output logic               frozen,
  output logic               wrap
);
  localparam logic [DIGIT_W-1:0] MAX_LO = DIGIT_W'(MIN_MAX % 10);
  localparam logic [DIGIT_W-1:0] MAX_HI = DIGIT_W'(MIN_MAX / 10);

  logic       r_sync1, r_sync2, r_sync_d, r_armed;
  logic [1:0] r_warm;
  logic       w_tick, w_inc, w_clr, w_min_wrap, w_min_clr;
  logic       w_c0, w_c1, w_c2, w_c3;
  sw_state_e  r_state, w_state_nxt;
  logic [DIGIT_W-1:0] w_sl, w_sh, w_ml, w_mh;
  logic [DIGIT_W-1:0] w_sl_nxt, w_sh_nxt, w_ml_nxt, w_mh_nxt;
  logic [4*DIGIT_W-1:0] r_disp;
  logic       r_running, r_frozen, r_wrap;

  // Edge detect is armed only after a genuine post-reset low, so a level
  // already high at reset release does not count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
      r_warm   <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_sync1  <= clk_sec;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_warm   <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_sync2) r_armed <= 1'b1;
    end
  end

  assign w_tick = r_sync2 & ~r_sync_d & r_armed;

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (stop) begin
      if (r_state == RUN || r_state == LAP) w_state_nxt = PAUSE;
    end else if (start) begin
      if (r_state == IDLE || r_state == PAUSE) w_state_nxt = RUN;
    end else if (lap) begin
      if (r_state == RUN) w_state_nxt = LAP;
      else if (r_state == LAP) w_state_nxt = RUN;
    end
  end

  assign w_inc      = w_tick & (r_state == RUN || r_state == LAP);
  assign w_clr      = clear;
  assign w_min_wrap = w_c1 & (w_mh == MAX_HI) & (w_ml == MAX_LO);
  assign w_min_clr  = w_clr | w_min_wrap;

  sw_bcd_cnt u_sec_lo (.clk(clk), .reset(reset), .i_en(w_inc), .i_clr(w_clr),
    .i_limit(DIGIT_MAX), .o_q(w_sl), .o_q_nxt(w_sl_nxt), .o_carry(w_c0));
  sw_bcd_cnt u_sec_hi (.clk(clk), .reset(reset), .i_en(w_c0), .i_clr(w_clr),
    .i_limit(SEC_HIGH_MAX), .o_q(w_sh), .o_q_nxt(w_sh_nxt), .o_carry(w_c1));
  sw_bcd_cnt u_min_lo (.clk(clk), .reset(reset), .i_en(w_c1), .i_clr(w_min_clr),
    .i_limit(DIGIT_MAX), .o_q(w_ml), .o_q_nxt(w_ml_nxt), .o_carry(w_c2));
  sw_bcd_cnt u_min_hi (.clk(clk), .reset(reset), .i_en(w_c2), .i_clr(w_min_clr),
    .i_limit(DIGIT_MAX), .o_q(w_mh), .o_q_nxt(w_mh_nxt), .o_carry(w_c3));

  // Entering or staying in LAP keeps the display at its pre-increment value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_disp    <= '0;
      r_running <= 1'b0;
      r_frozen  <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      if (w_state_nxt != LAP) r_disp <= {w_mh_nxt, w_ml_nxt, w_sh_nxt, w_sl_nxt};
      r_running <= (w_state_nxt == RUN) || (w_state_nxt == LAP);
      r_frozen  <= (w_state_nxt == LAP);
      r_wrap    <= w_min_wrap & ~w_clr;
    end
  end

  assign {min_high, min_low, sec_high, sec_low} = r_disp;
  assign running = r_running;
  assign frozen  = r_frozen;
  assign wrap    = r_wrap;
endmodule

// File: tb/tb_sw_gen_sec_min.sv
// tb/tb_sw_gen_sec_min.sv - randomized and directed self-checking bench for sw_gen_sec_min
module tb_sw_gen_sec_min;
  localparam int MIN_MAX = 59;
  localparam int SPAN = (MIN_MAX + 1) * 60;
  localparam logic [3:0] C_NONE = 4'b0000, C_CLR = 4'b1000, C_STOP = 4'b0100,
                         C_START = 4'b0010, C_LAP = 4'b0001;

  logic clk = 1'b0, reset = 1'b0, clk_sec = 1'b0;
  logic start = 1'b0, stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] sec_low, sec_high, min_low, min_high;
  logic running, frozen, wrap;

  int total = 0, bad = 0;

  // state codes: 0 idle, 1 run, 2 pause, 3 lap; command codes: 0 none, 1 clear, 2 stop, 3 start, 4 lap
  int tab [4][5] = '{'{0, 0, 0, 1, 0}, '{1, 0, 2, 1, 3}, '{2, 0, 2, 1, 2}, '{3, 0, 2, 3, 1}};
  int m_st = 0, m_live = 0, m_disp = 0, m_k = 0;
  bit m_wrap = 0, s1 = 0, s2 = 0, s3 = 0, s4 = 0;

  always #5 clk = ~clk;

  sw_gen_sec_min #(.MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .reset(reset), .clk_sec(clk_sec),
    .start(start), .stop(stop), .lap(lap), .clear(clear),
    .sec_low(sec_low), .sec_high(sec_high), .min_low(min_low), .min_high(min_high),
    .running(running), .frozen(frozen), .wrap(wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    int sec, mn;
    sec = t % 60;
    mn  = t / 60;
    return 16'((mn / 10) << 12 | (mn % 10) << 8 | (sec / 10) << 4 | (sec % 10));
  endfunction

  function automatic logic [15:0] dig();
    return {min_high, min_low, sec_high, sec_low};
  endfunction

  task automatic model_edge();
    bit tick;
    int cmd, nx;
    if (!reset) begin
      m_st = 0; m_live = 0; m_disp = 0; m_k = 0; m_wrap = 0;
      s1 = 0; s2 = 0; s3 = 0; s4 = 0;
      return;
    end
    m_k++;
    s4 = s3; s3 = s2; s2 = s1; s1 = clk_sec;
    tick = (m_k >= 4) && s3 && !s4;
    cmd = clear ? 1 : stop ? 2 : start ? 3 : lap ? 4 : 0;
    nx = tab[m_st][cmd];
    m_wrap = 0;
    if (clear) begin
      m_live = 0;
    end else if (tick && (m_st == 1 || m_st == 3)) begin
      m_live++;
      if (m_live == SPAN) begin
        m_live = 0;
        m_wrap = 1;
      end
    end
    if (nx != 3) m_disp = m_live;
    m_st = nx;
  endtask

  task automatic cyc(input bit cs, input logic [3:0] cm);
    clk_sec = cs;
    {clear, stop, start, lap} = cm;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("digits", 32'(dig()), 32'(to_bcd(m_disp)));
    chk("flags", {29'd0, running, frozen, wrap},
        {29'd0, (m_st == 1 || m_st == 3), (m_st == 3), m_wrap});
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, C_NONE); cyc(1, C_NONE); cyc(0, C_NONE); cyc(0, C_NONE);
    end
  endtask

  task automatic tick_with(input logic [3:0] cm);
    cyc(1, C_NONE); cyc(1, C_NONE); cyc(1, cm); cyc(0, C_NONE); cyc(0, C_NONE);
  endtask

  initial begin
    int wraps;
    bit cs_r;
    logic [3:0] cm;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cyc(0, C_NONE);
    chk("rst_digits", 32'(dig()), 32'h0);
    chk("rst_flags", {29'd0, running, frozen, wrap}, 32'h0);
    reset = 1'b1;
    repeat (4) cyc(0, C_NONE);

    cyc(0, C_START);
    pulse(75);
    chk("count75", 32'(dig()), 32'h0115);
    chk("count75_run", 32'(running), 32'h1);

    cyc(0, C_CLR); cyc(0, C_START);
    pulse(3598);
    chk("at5958", 32'(dig()), 32'h5958);
    pulse(1);
    chk("at5959", 32'(dig()), 32'h5959);
    wraps = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(i < 2, C_NONE);
      if (wrap) wraps++;
    end
    chk("wrap_once", 32'(wraps), 32'd1);
    chk("after_wrap", 32'(dig()), 32'h0000);

    cyc(0, C_CLR); cyc(0, C_START);
    pulse(10);
    cyc(0, C_LAP);
    pulse(5);
    chk("lap_hold", 32'(dig()), 32'h0010);
    chk("lap_frozen", 32'(frozen), 32'h1);
    cyc(0, C_LAP);
    chk("lap_release", 32'(dig()), 32'h0015);
    chk("lap_unfrozen", 32'(frozen), 32'h0);

    cyc(0, C_CLR); cyc(0, C_START);
    pulse(20);
    tick_with(C_STOP);
    chk("stop_tick", 32'(dig()), 32'h0021);
    chk("stop_paused", {30'd0, running, frozen}, 32'h0);
    pulse(3);
    chk("paused_hold", 32'(dig()), 32'h0021);

    cyc(0, C_CLR); cyc(0, C_START);
    pulse(187);
    chk("at0307", 32'(dig()), 32'h0307);
    tick_with(C_CLR);
    chk("clear_tick", 32'(dig()), 32'h0000);
    chk("clear_flags", {29'd0, running, frozen, wrap}, 32'h0);

    cyc(0, C_START);
    repeat (40) cyc(1, C_NONE);
    repeat (3) cyc(0, C_NONE);
    chk("held_high", 32'(dig()), 32'h0001);
    cyc(0, C_LAP);
    pulse(2);
    chk("lap_before_rst", 32'(frozen), 32'h1);
    reset = 1'b0;
    cyc(0, C_NONE);
    reset = 1'b1;
    chk("rst_in_lap", 32'(dig()), 32'h0000);
    chk("rst_in_lap_frz", 32'(frozen), 32'h0);

    reset = 1'b0;
    repeat (3) cyc(1, C_NONE);
    reset = 1'b1;
    cyc(1, C_START);
    repeat (10) cyc(1, C_NONE);
    chk("high_at_release", 32'(dig()), 32'h0000);
    repeat (3) cyc(0, C_NONE);
    pulse(1);
    chk("after_rearm", 32'(dig()), 32'h0001);

    cs_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) cs_r = ~cs_r;
      for (int b = 0; b < 4; b++) cm[b] = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 599) != 0);
      cyc(cs_r, cm);
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
